seq_game_ctrl: RTL
==================

SEQ_GAME_CTRL -- requirements
Module: seq_game_ctrl

Interface
REQ-001 SHALL have parameter COLOR_W, default 2, bit width of one color symbol.
REQ-002 SHALL have parameter DEPTH, default 32, maximum sequence length (2..256); SCORE_W = clog2(DEPTH+1).
REQ-003 SHALL have parameter TIMEOUT_PULSES, default 3, TIMER_PULSE count allowed per input before a timeout loss.
REQ-004 SHALL have a single clock CLK; reset RST is asynchronous and active-high.
REQ-005 CLK  in  1  system clock, rising edge.
REQ-006 RST  in  1  asynchronous active-high reset.
REQ-007 START_GAME  in  1  begin a new game; sampled in IDLE only.
REQ-008 IN  in  COLOR_W  player color, valid when IN_VALID.
REQ-009 IN_VALID  in  1  one-cycle pulse per player press.
REQ-010 RAND  in  COLOR_W  random color, sampled in ADD.
REQ-011 TIMER_PULSE  in  1  one-cycle pulse when the external delay timer expires.
REQ-012 TIMER_GO  out  1  one-cycle pulse that (re)starts the external timer.
REQ-013 OUT  out  COLOR_W  color being displayed; OUT_ENA  out  1  display enable.
REQ-014 WIN, LOSE  out  1 each  game-result levels; HS  out  1  one-cycle new-high-score pulse.
REQ-015 SCORE, HIGH_SCORE  out  SCORE_W each  completed rounds of current game / best score since reset; BUSY  out  1  high when state != IDLE.

Function
REQ-016 SHALL implement states IDLE, ADD, SHOW, SHOW_WAIT, INPUT, END; len = stored sequence length, i = index.
REQ-017 IDLE: on START_GAME, SHALL clear len, i, SCORE, WIN, LOSE and go to ADD next cycle.
REQ-018 ADD: if len == DEPTH SHALL set WIN=1 and go to END; else SHALL write RAND to stack[len], increment len, clear i, go to SHOW.
REQ-019 SHOW: SHALL drive OUT=stack[i], OUT_ENA=1, pulse TIMER_GO for one cycle, go to SHOW_WAIT.
REQ-020 SHOW_WAIT: on TIMER_PULSE SHALL drop OUT_ENA; if i == len-1 clear i and go to INPUT, else increment i and return to SHOW.
REQ-021 INPUT: on IN_VALID with IN == stack[i], SHALL increment i; if i == len-1, SCORE <= len, i <= 0, go to ADD.
REQ-022 INPUT: on IN_VALID with IN != stack[i], SHALL set LOSE=1 and go to END.
REQ-023 END: if SCORE > HIGH_SCORE SHALL load HIGH_SCORE <= SCORE and pulse HS once; SHALL return to IDLE next cycle.
REQ-024 WIN and LOSE SHALL hold until the next accepted START_GAME or reset; never both high.
REQ-025 START_GAME outside IDLE, IN_VALID outside INPUT and TIMER_PULSE outside SHOW_WAIT/INPUT SHALL be ignored.
REQ-026 IN_VALID and TIMER_PULSE in the same INPUT cycle: the input SHALL be processed and the pulse ignored.
REQ-027 OUT SHALL hold its last value when OUT_ENA is low; TIMER_GO and HS are low in every cycle not listed above.

Reset
REQ-028 On RST, SHALL force state IDLE, i=0, len=0, SCORE=0, HIGH_SCORE=0, OUT=all-ones, OUT_ENA=0, TIMER_GO=0, WIN=0, LOSE=0, HS=0.
REQ-029 Reset mid-game SHALL abort immediately with no HS pulse; stack contents need not be cleared.

Configuration
REQ-030 Macro SEQ_GAME_TIMEOUT_EN defined: TIMER_GO SHALL pulse on INPUT entry and after each correct non-final press; TIMEOUT_PULSES TIMER_PULSEs without IN_VALID SHALL set LOSE=1 and go to END.
REQ-031 Macro undefined: INPUT SHALL wait indefinitely, no TIMER_GO is issued from INPUT, timeout counter SHALL not exist.

Verification
REQ-032 Reset, START_GAME, RAND=2 -> OUT=2 with OUT_ENA=1 and TIMER_GO pulse; after TIMER_PULSE, BUSY=1 in INPUT.
REQ-033 Three rounds with correct IN each round -> SCORE=3, each round replays full sequence in order.
REQ-034 Round 2, wrong color on first press -> LOSE=1, WIN=0, SCORE=1, HS pulse, HIGH_SCORE=1, BUSY=0.
REQ-035 DEPTH=4, perfect play -> after 4th round WIN=1, SCORE=4, HIGH_SCORE=4; second game losing at SCORE=2 -> no HS, HIGH_SCORE=4.
REQ-036 SEQ_GAME_TIMEOUT_EN, TIMEOUT_PULSES=3, no input, 3 TIMER_PULSEs -> LOSE=1; 2 pulses then correct press -> continues.
REQ-037 RST asserted during SHOW_WAIT -> all outputs at reset values, START_GAME restarts with len=1.

Source files
------------

// File: rtl/seq_game_ctrl.sv
// seq_game_ctrl: memory-sequence game controller (Simon-style).
// Grows a random color sequence by one symbol per round, replays it with
// external-timer pacing, then checks the player's presses against it.
// Optional feature: define SEQ_GAME_TIMEOUT_EN to make the INPUT state lose
// after TIMEOUT_PULSES timer expiries without a press.
module seq_game_ctrl #(
    parameter int unsigned COLOR_W        = 2,
    parameter int unsigned DEPTH          = 32,
    parameter int unsigned TIMEOUT_PULSES = 3,
    localparam int unsigned SCORE_W       = $clog2(DEPTH + 1)
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               START_GAME,
    input  logic [COLOR_W-1:0] IN,
    input  logic               IN_VALID,
    input  logic [COLOR_W-1:0] RAND,
    input  logic               TIMER_PULSE,
    output logic               TIMER_GO,
    output logic [COLOR_W-1:0] OUT,
    output logic               OUT_ENA,
    output logic               WIN,
    output logic               LOSE,
    output logic               HS,
    output logic [SCORE_W-1:0] SCORE,
    output logic [SCORE_W-1:0] HIGH_SCORE,
    output logic               BUSY
);

    localparam int unsigned        AW      = $clog2(DEPTH);
    localparam logic [SCORE_W-1:0] LEN_MAX = SCORE_W'(DEPTH);
    localparam logic [SCORE_W-1:0] ONE     = SCORE_W'(1);

    if (DEPTH < 2 || DEPTH > 256) begin : g_bad_depth
        $error("seq_game_ctrl: DEPTH must lie in 2..256");
    end
    if (TIMEOUT_PULSES < 1) begin : g_bad_timeout
        $error("seq_game_ctrl: TIMEOUT_PULSES must be at least 1");
    end
    if (COLOR_W < 1) begin : g_bad_color
        $error("seq_game_ctrl: COLOR_W must be at least 1");
    end

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADD,
        ST_SHOW,
        ST_SHOW_WAIT,
        ST_INPUT,
        ST_END
    } state_t;

    state_t               r_state;
    logic [SCORE_W-1:0]   r_len;
    logic [SCORE_W-1:0]   r_i;
    logic [SCORE_W-1:0]   r_score;
    logic [SCORE_W-1:0]   r_high;
    logic [COLOR_W-1:0]   r_out;
    logic                 r_out_ena;
    logic                 r_timer_go;
    logic                 r_win;
    logic                 r_lose;
    logic                 r_hs;
    logic [COLOR_W-1:0]   r_stack [0:(1 << AW) - 1];

`ifdef SEQ_GAME_TIMEOUT_EN
    localparam int unsigned   TO_W    = $clog2(TIMEOUT_PULSES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_PULSES - 1);
    logic [TO_W-1:0]          r_to_cnt;
`endif

    logic                 w_stack_we;
    logic [COLOR_W-1:0]   w_rd_data;
    logic                 w_last;

    assign w_stack_we = (r_state == ST_ADD) && (r_len != LEN_MAX);
    assign w_rd_data  = r_stack[r_i[AW-1:0]];
    assign w_last     = (r_i == (r_len - ONE));

    // Sequence storage: one new symbol appended per round, never cleared.
    always_ff @(posedge CLK) begin
        if (w_stack_we) begin
            r_stack[r_len[AW-1:0]] <= RAND;
        end
    end

    // Game FSM with registered outputs; TIMER_GO and HS default low each cycle.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state    <= ST_IDLE;
            r_len      <= '0;
            r_i        <= '0;
            r_score    <= '0;
            r_high     <= '0;
            r_out      <= '1;
            r_out_ena  <= 1'b0;
            r_timer_go <= 1'b0;
            r_win      <= 1'b0;
            r_lose     <= 1'b0;
            r_hs       <= 1'b0;
`ifdef SEQ_GAME_TIMEOUT_EN
            r_to_cnt   <= '0;
`endif
        end else begin
            r_timer_go <= 1'b0;
            r_hs       <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (START_GAME) begin
                        r_len   <= '0;
                        r_i     <= '0;
                        r_score <= '0;
                        r_win   <= 1'b0;
                        r_lose  <= 1'b0;
                        r_state <= ST_ADD;
                    end
                end
                ST_ADD: begin
                    if (r_len == LEN_MAX) begin
                        r_win   <= 1'b1;
                        r_state <= ST_END;
                    end else begin
                        r_len   <= r_len + ONE;
                        r_i     <= '0;
                        r_state <= ST_SHOW;
                    end
                end
                ST_SHOW: begin
                    r_out      <= w_rd_data;
                    r_out_ena  <= 1'b1;
                    r_timer_go <= 1'b1;
                    r_state    <= ST_SHOW_WAIT;
                end
                ST_SHOW_WAIT: begin
                    if (TIMER_PULSE) begin
                        r_out_ena <= 1'b0;
                        if (w_last) begin
                            r_i     <= '0;
                            r_state <= ST_INPUT;
`ifdef SEQ_GAME_TIMEOUT_EN
                            r_timer_go <= 1'b1;
                            r_to_cnt   <= '0;
`endif
                        end else begin
                            r_i     <= r_i + ONE;
                            r_state <= ST_SHOW;
                        end
                    end
                end
                ST_INPUT: begin
                    // A press always wins over a coincident timer expiry.
                    if (IN_VALID) begin
                        if (IN == w_rd_data) begin
                            if (w_last) begin
                                r_score <= r_len;
                                r_i     <= '0;
                                r_state <= ST_ADD;
                            end else begin
                                r_i <= r_i + ONE;
`ifdef SEQ_GAME_TIMEOUT_EN
                                r_timer_go <= 1'b1;
                                r_to_cnt   <= '0;
`endif
                            end
                        end else begin
                            r_lose  <= 1'b1;
                            r_state <= ST_END;
                        end
                    end
`ifdef SEQ_GAME_TIMEOUT_EN
                    else if (TIMER_PULSE) begin
                        if (r_to_cnt == TO_LAST) begin
                            r_lose  <= 1'b1;
                            r_state <= ST_END;
                        end else begin
                            r_to_cnt <= r_to_cnt + 1'b1;
                        end
                    end
`endif
                end
                ST_END: begin
                    if (r_score > r_high) begin
                        r_high <= r_score;
                        r_hs   <= 1'b1;
                    end
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign TIMER_GO   = r_timer_go;
    assign OUT        = r_out;
    assign OUT_ENA    = r_out_ena;
    assign WIN        = r_win;
    assign LOSE       = r_lose;
    assign HS         = r_hs;
    assign SCORE      = r_score;
    assign HIGH_SCORE = r_high;
    assign BUSY       = (r_state != ST_IDLE);

endmodule
